arb_mux: RTL and testbench
==========================

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter NUM_CH, default 8, number of input channels (2..32).
REQ-002 Parameter WIDTH, default 8, data width per channel (1..64).
REQ-003 Parameter SW, default $clog2(NUM_CH), select/channel-index width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 mode  input  1  0 = fixed select (sel), 1 = round-robin.
REQ-007 sel  input  SW  channel index used when mode=0.
REQ-008 in_valid  input  NUM_CH  per-channel valid.
REQ-009 in_data  input  NUM_CH*WIDTH  packed channel data; channel i in bits [i*WIDTH +: WIDTH].
REQ-010 in_ready  output  NUM_CH  per-channel ready, combinational.
REQ-011 out_valid  output  1  output register holds a beat.
REQ-012 out_data  output  WIDTH  registered data of held beat.
REQ-013 out_ch  output  SW  registered index of the channel that supplied the held beat.
REQ-014 out_ready  input  1  downstream accepts beat when out_valid=1.

Function
REQ-015 Output stage SHALL be a two-state machine: EMPTY (out_valid=0), FULL (out_valid=1).
REQ-016 load = (state==EMPTY) or (out_ready=1); load SHALL enable one input transfer per cycle.
REQ-017 mode=0: grant SHALL be channel sel iff in_valid[sel]=1 and sel<NUM_CH; otherwise no grant.
REQ-018 mode=1: grant SHALL be the first channel with in_valid=1, searching from rr_ptr+1 upward, wrapping NUM_CH-1 -> 0, rr_ptr itself checked last.
REQ-019 in_ready[i] SHALL be 1 only for the granted channel and only when load=1; all other bits 0.
REQ-020 Transfer SHALL occur when in_valid[g] and in_ready[g] are both 1; at that edge out_data<=in_data[g], out_ch<=g, out_valid<=1.
REQ-021 Latency SHALL be exactly 1 cycle from input transfer to out_valid=1.
REQ-022 FULL with out_ready=1 and a grant SHALL reload in the same edge (back-to-back, 1 beat/cycle sustained).
REQ-023 FULL with out_ready=1 and no grant SHALL go to EMPTY.
REQ-024 FULL with out_ready=0 SHALL hold out_data, out_ch, out_valid unchanged; in_ready all 0.
REQ-025 rr_ptr (SW bits) SHALL update to g only on a transfer made with mode=1; unchanged otherwise, including fixed-mode transfers.
REQ-026 Mode or sel changes SHALL affect only the grant in the cycle they are sampled; a held beat is never altered.
REQ-027 With a single valid channel, round-robin SHALL grant it every cycle regardless of rr_ptr.
REQ-028 No grant SHALL be issued to a channel with in_valid=0; in_data of non-granted channels SHALL not affect outputs.

Reset
REQ-029 While rst=1: state=EMPTY, out_valid=0, out_data=0, out_ch=0, rr_ptr=NUM_CH-1, immediately without clock.
REQ-030 in_ready SHALL be all 0 while rst=1.
REQ-031 rst asserted while FULL SHALL discard the held beat; no beat SHALL appear after deassertion until a new transfer.
REQ-032 After rst deasserts, first round-robin grant SHALL go to the lowest-indexed valid channel.

Verification
REQ-033 Reset: NUM_CH=8, WIDTH=8, all in_valid=1 during rst -> in_ready=0, out_valid=0, out_data=0x00, out_ch=0.
REQ-034 Fixed: mode=0, sel=5, in_valid=8'hFF, in_data ch5=0xA5, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, out_ch=5, in_ready=8'h20 each cycle.
REQ-035 Round-robin fairness: mode=1, in_valid=8'b1001_0010, out_ready=1 -> out_ch sequence 1,4,7,1,4,7.
REQ-036 Backpressure: FULL with out_data=0x3C, out_ready=0 for 4 cycles, input data changing -> out_data stays 0x3C, in_ready=0; out_ready=1 -> next beat loads same edge.
REQ-037 Drain: single beat, then in_valid=0, out_ready=1 -> out_valid falls to 0 one cycle after beat accepted.
REQ-038 Mid-operation reset: mode=1, rr_ptr=4, FULL, rst pulse asynchronous mid-cycle -> out_valid=0 at once; afterwards in_valid=8'b0011_0000 -> first out_ch=4.

Source files
------------

// File: rtl/arb_mux.sv
// Arbitrating mux: fixed-select or round-robin grant over NUM_CH channels into one
// registered output beat; 1-cycle latency, sustains 1 beat/cycle, stalls inputs on out_ready=0.
module arb_mux #(
  parameter int NUM_CH = 8,
  parameter int WIDTH  = 8,
  parameter int SW     = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [SW-1:0]           sel,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SW-1:0]           out_ch,
  input  logic                    out_ready
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SW-1:0]     out_ch_q, out_ch_d;
  logic [SW-1:0]     rr_ptr_q, rr_ptr_d;

  logic              load;
  logic              grant_vld;
  logic [SW-1:0]     grant;
  logic              xfer;
  int                idx;

  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    if (!mode) begin
      if (int'(sel) < NUM_CH && in_valid[sel]) begin
        grant_vld = 1'b1;
        grant     = sel;
      end
    end else begin
      // Walk from farthest to nearest so the channel just after rr_ptr wins; rr_ptr is last.
      for (int k = NUM_CH; k >= 1; k--) begin
        idx = (int'(rr_ptr_q) + k) % NUM_CH;
        if (in_valid[idx]) begin
          grant_vld = 1'b1;
          grant     = SW'(idx);
        end
      end
    end
  end

  assign load     = (state_q == EMPTY) || out_ready;
  assign xfer     = load && grant_vld && !rst;
  assign in_ready = xfer ? ({{(NUM_CH-1){1'b0}}, 1'b1} << grant) : '0;

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    rr_ptr_d   = rr_ptr_q;
    if (xfer) begin
      state_d    = FULL;
      out_data_d = in_data[int'(grant)*WIDTH +: WIDTH];
      out_ch_d   = grant;
      if (mode) rr_ptr_d = grant;
    end else if (out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_ch_q   <= '0;
      rr_ptr_q   <= SW'(NUM_CH - 1);
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: expected beats queued as stimulus is driven, popped when the output is accepted.
module tb_arb_mux;
  localparam int NUM_CH = 8;
  localparam int WIDTH  = 8;
  localparam int SW     = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    mode;
  logic [SW-1:0]           sel;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SW-1:0]           out_ch;
  logic                    out_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [SW+WIDTH-1:0] exp_q[$];

  arb_mux #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .SW(SW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Output side of the scoreboard: each accepted beat is compared to the oldest expectation.
  always @(negedge clk) begin
    logic [SW+WIDTH-1:0] e;
    if (!rst && out_valid && out_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected: got ch=%0d data=%02h, required no beat", out_ch, out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_ch, out_data} !== e) begin
          tests_failed++;
          $display("FAIL sb_beat: got ch=%0d data=%02h, required ch=%0d data=%02h",
                   out_ch, out_data, e[SW+WIDTH-1:WIDTH], e[WIDTH-1:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < NUM_CH; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b1; sel = '0; in_valid = 8'hFF; out_ready = 1'b1;
    randomize_data();
    #1;
    for (int c = 0; c < 2; c++) begin
      tests_run++;
      if (in_ready !== 8'h00) begin
        tests_failed++; $display("FAIL reset_in_ready: got %02h, required 00", in_ready);
      end
      tests_run++;
      if ({out_valid, out_data, out_ch} !== 12'h000) begin
        tests_failed++;
        $display("FAIL reset_outputs: got valid=%b data=%02h ch=%0d, required 0/00/0", out_valid, out_data, out_ch);
      end
      tick();
    end
    in_valid = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fixed();
    mode = 1'b0; sel = 3'd5; out_ready = 1'b1; in_valid = 8'hFF;
    for (int c = 0; c < 4; c++) begin
      randomize_data();
      in_data[5*WIDTH +: WIDTH] = 8'hA5;
      #1;
      tests_run++;
      if (in_ready !== 8'h20) begin
        tests_failed++; $display("FAIL fixed_in_ready: got %02h, required 20", in_ready);
      end
      exp_q.push_back({3'd5, 8'hA5});
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_ch !== 3'd5 || out_data !== 8'hA5) begin
        tests_failed++;
        $display("FAIL fixed_out: got valid=%b ch=%0d data=%02h, required 1/5/a5", out_valid, out_ch, out_data);
      end
    end
    // Selected channel not valid: no grant even though others are valid.
    sel = 3'd2; in_valid = 8'b1111_1011;
    #1;
    tests_run++;
    if (in_ready !== 8'h00) begin
      tests_failed++; $display("FAIL fixed_sel_invalid: got %02h, required 00", in_ready);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL fixed_drain: got out_valid=%b, required 0", out_valid);
    end
    in_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [SW-1:0] seq [6];
    logic [WIDTH-1:0] d;
    seq = '{3'd1, 3'd4, 3'd7, 3'd1, 3'd4, 3'd7};
    mode = 1'b1; out_ready = 1'b1; in_valid = 8'b1001_0010;
    for (int c = 0; c < 6; c++) begin
      randomize_data();
      d = WIDTH'(8'h40 + c);
      in_data[int'(seq[c])*WIDTH +: WIDTH] = d;
      #1;
      tests_run++;
      if (in_ready !== (8'h01 << seq[c])) begin
        tests_failed++;
        $display("FAIL rr_in_ready[%0d]: got %02h, required %02h", c, in_ready, 8'h01 << seq[c]);
      end
      exp_q.push_back({seq[c], d});
      tick();
    end
    in_valid = '0;
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL rr_drain: got out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    mode = 1'b0; sel = 3'd3; in_valid = 8'h08; out_ready = 1'b0;
    randomize_data();
    in_data[3*WIDTH +: WIDTH] = 8'h3C;
    #1;
    exp_q.push_back({3'd3, 8'h3C});
    tick();
    in_valid = 8'hFF;
    for (int c = 0; c < 4; c++) begin
      randomize_data();
      in_data[3*WIDTH +: WIDTH] = WIDTH'(8'h50 + c);
      #1;
      tests_run++;
      if (in_ready !== 8'h00) begin
        tests_failed++; $display("FAIL bp_in_ready: got %02h, required 00", in_ready);
      end
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || out_ch !== 3'd3) begin
        tests_failed++;
        $display("FAIL bp_hold: got valid=%b data=%02h ch=%0d, required 1/3c/3", out_valid, out_data, out_ch);
      end
    end
    out_ready = 1'b1;
    in_data[3*WIDTH +: WIDTH] = 8'h77;
    #1;
    tests_run++;
    if (in_ready !== 8'h08) begin
      tests_failed++; $display("FAIL bp_reload_ready: got %02h, required 08", in_ready);
    end
    exp_q.push_back({3'd3, 8'h77});
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 8'h77) begin
      tests_failed++; $display("FAIL bp_reload: got valid=%b data=%02h, required 1/77", out_valid, out_data);
    end
    in_valid = '0;
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL bp_drain: got out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_single_rr();
    mode = 1'b1; out_ready = 1'b1; in_valid = 8'h04;
    for (int c = 0; c < 3; c++) begin
      randomize_data();
      #1;
      tests_run++;
      if (in_ready !== 8'h04) begin
        tests_failed++; $display("FAIL single_rr_ready[%0d]: got %02h, required 04", c, in_ready);
      end
      exp_q.push_back({3'd2, in_data[2*WIDTH +: WIDTH]});
      tick();
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_mid_reset();
    mode = 1'b1; out_ready = 1'b1; in_valid = 8'h10;
    randomize_data();
    in_data[4*WIDTH +: WIDTH] = 8'h99;
    exp_q.push_back({3'd4, 8'h99});
    tick();
    out_ready = 1'b0; in_valid = '0;
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 3'd0 || in_ready !== 8'h00) begin
      tests_failed++;
      $display("FAIL midrst_async: got valid=%b data=%02h ch=%0d ready=%02h, required 0/00/0/00",
               out_valid, out_data, out_ch, in_ready);
    end
    tick();
    rst = 1'b0; out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_no_ghost: got out_valid=%b, required 0", out_valid);
    end
    in_valid = 8'b0011_0000;
    randomize_data();
    #1;
    tests_run++;
    if (in_ready !== 8'h10) begin
      tests_failed++; $display("FAIL midrst_first_grant: got %02h, required 10", in_ready);
    end
    exp_q.push_back({3'd4, in_data[4*WIDTH +: WIDTH]});
    tick();
    tests_run++;
    if (out_ch !== 3'd4 || out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL midrst_out_ch: got valid=%b ch=%0d, required 1/4", out_valid, out_ch);
    end
    randomize_data();
    #1;
    tests_run++;
    if (in_ready !== 8'h20) begin
      tests_failed++; $display("FAIL midrst_next_grant: got %02h, required 20", in_ready);
    end
    exp_q.push_back({3'd5, in_data[5*WIDTH +: WIDTH]});
    tick();
    in_valid = '0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_single_rr();
    test_mid_reset();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++; $display("FAIL sb_leftover: got %0d pending beats, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
